snp_req_hdlr: RTL



---
 rtl/snp_req_hdlr.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/snp_req_hdlr.sv
// Snoop-request handler for one L1 cache controller.
//
// Accepts one bus snoop at a time, looks the indexed line up in the shared
// cache array, applies the MESI snoop transition and answers with a snoop
// response (plus line data when this cache supplies it).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sureq_*               snoop request channel (valid/ready, op, line address)
//   sdrsp_*               snoop response channel (valid/ready, code, line data)
//   arr_rd_*/arr_gnt      arbitrated array read port; data valid the cycle after grant
//   arr_wr_*              state write-back port, always accepted
//
// Encodings shared with the rest of the controller:
//   SUREQ: RD=0, RFO=1, INV=2, 3=no-op snoop
//   SDRSP: OKAY=0 (data supplied), INV=1
//   MESI : I=3'b000, S=3'b010, E=3'b101, M=3'b111 (bit 0 set = owner, supplies data)
module snp_req_hdlr #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned OFFSET_WIDTH = 6,
    parameter int unsigned IDX_WIDTH    = 8,
    parameter int unsigned BLK_WIDTH    = 512
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       sureq_valid,
    output logic                                       sureq_ready,
    input  logic [1:0]                                 sureq_op,
    input  logic [ADDR_WIDTH-1:0]                      sureq_addr,
    output logic                                       sdrsp_valid,
    input  logic                                       sdrsp_ready,
    output logic [1:0]                                 sdrsp_rsp,
    output logic [BLK_WIDTH-1:0]                       sdrsp_data,
    output logic                                       arr_rd_en,
    input  logic                                       arr_gnt,
    output logic [IDX_WIDTH-1:0]                       arr_rd_idx,
    input  logic [ADDR_WIDTH-IDX_WIDTH-OFFSET_WIDTH-1:0] arr_rd_tag,
    input  logic [2:0]                                 arr_rd_st,
    input  logic [BLK_WIDTH-1:0]                       arr_rd_data,
    output logic                                       arr_wr_en,
    output logic [IDX_WIDTH-1:0]                       arr_wr_idx,
    output logic [2:0]                                 arr_wr_st
);

    localparam int unsigned TagWidth = ADDR_WIDTH - IDX_WIDTH - OFFSET_WIDTH;

    localparam logic [1:0] SureqRd  = 2'd0;
    localparam logic [1:0] SureqRfo = 2'd1;
    localparam logic [1:0] SureqInv = 2'd2;

    localparam logic [1:0] SdrspOkay = 2'd0;
    localparam logic [1:0] SdrspInv  = 2'd1;

    localparam logic [2:0] MesiInvalid = 3'b000;
    localparam logic [2:0] MesiShared  = 3'b010;

    typedef enum logic [1:0] {StIdle, StLookup, StUpdate, StResp} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [TagWidth-1:0]    tag_q, tag_d;
    logic [1:0]             rsp_q, rsp_d;
    logic [BLK_WIDTH-1:0]   data_q, data_d;

    logic                   hit;
    logic                   supply;
    logic [2:0]             new_st;

    // Offset bits never matter for a line-granular snoop.
    logic unused_offset;
    assign unused_offset = ^sureq_addr[OFFSET_WIDTH-1:0];

    // Lookup result; only meaningful in StUpdate, when arr_rd_* carry the granted read.
    always_comb begin
        hit = (arr_rd_tag == tag_q) && (arr_rd_st != MesiInvalid);
        case (op_q)
            SureqRd:            new_st = MesiShared;
            SureqInv, SureqRfo: new_st = MesiInvalid;
            default:            new_st = arr_rd_st;
        endcase
        supply = hit && arr_rd_st[0] && ((op_q == SureqRd) || (op_q == SureqRfo));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        rsp_d   = rsp_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (sureq_valid) begin
                    op_d    = sureq_op;
                    idx_d   = sureq_addr[OFFSET_WIDTH+IDX_WIDTH-1:OFFSET_WIDTH];
                    tag_d   = sureq_addr[ADDR_WIDTH-1:OFFSET_WIDTH+IDX_WIDTH];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (arr_gnt) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                // Capture the response here so it stays stable while the bus stalls.
                rsp_d   = supply ? SdrspOkay : SdrspInv;
                data_d  = supply ? arr_rd_data : '0;
                state_d = StResp;
            end
            StResp: begin
                if (sdrsp_ready) begin
                    rsp_d   = SdrspInv;
                    data_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            rsp_q   <= SdrspInv;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            rsp_q   <= rsp_d;
            data_q  <= data_d;
        end
    end

    // Handshake strobes are masked by rst_n so a reset cycle can neither
    // accept, write nor complete a response.
    assign sureq_ready = rst_n && (state_q == StIdle);
    assign arr_rd_en   = (state_q == StLookup);
    assign arr_rd_idx  = idx_q;
    assign arr_wr_en   = rst_n && (state_q == StUpdate) && hit;
    assign arr_wr_idx  = arr_wr_en ? idx_q : '0;
    assign arr_wr_st   = arr_wr_en ? new_st : '0;
    assign sdrsp_valid = rst_n && (state_q == StResp);
    assign sdrsp_rsp   = rsp_q;
    assign sdrsp_data  = data_q;

endmodule
